// File: rtl/registers_dump_unit_pkg.sv
// Shared debug-side definitions for the register dump unit: FSM encoding,
// byte geometry and counter sizing helpers.
package registers_dump_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } dump_state_e;

  localparam int NB_BYTE         = 8;
  localparam int NB_DATA_DEFAULT = 32;
  localparam int BYTES_PER_WORD  = NB_DATA_DEFAULT / NB_BYTE;

  function automatic int bytes_per_word(input int nb_data);
    return nb_data / NB_BYTE;
  endfunction

  // A word of a single byte still needs a 1-bit counter to stay well formed.
  function automatic int byte_cnt_width(input int nb_data);
    int n;
    n = nb_data / NB_BYTE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NB_BYTE_CNT = byte_cnt_width(NB_DATA_DEFAULT);

endpackage

// File: rtl/registers_dump_unit.sv
// Walks the register bank through its registered read port and serializes
// every word, LSB byte first, onto the UART TX start/done handshake.
module registers_dump_unit
  import registers_dump_unit_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEFAULT,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic               i_tx_done,
  output logic [NB_ADDR-1:0] o_reg_addr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam int WORD_BYTES = bytes_per_word(NB_DATA);
  localparam int NB_CNT     = byte_cnt_width(NB_DATA);

  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(WORD_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(BANK_DEPTH - 1);

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and infers a latch.
    state_d    = state_q;
    reg_addr_d = reg_addr_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_READ;
          reg_addr_d = '0;
          byte_cnt_d = '0;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shift_d = i_reg_data;
        state_d = ST_SEND;
      end
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_cnt_q < LAST_BYTE) begin
            shift_d    = shift_q >> NB_BYTE;
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = ST_SEND;
          end else if (reg_addr_q < LAST_ADDR) begin
            reg_addr_d = reg_addr_q + 1'b1;
            byte_cnt_d = '0;
            state_d    = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they land registered on entry.
    tx_data_d  = (state_d == ST_SEND) ? shift_d[NB_BYTE-1:0] : tx_data_q;
    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      reg_addr_q <= '0;
      // NOTE: the shift register is a plain flop vector, so it is reset along with the control state.
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_addr_q <= reg_addr_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_reg_addr = reg_addr_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_registers_dump_unit.sv
// Directed bench for registers_dump_unit: bank and UART TX models, with a
// byte scoreboard filled at dump start and drained on each o_tx_start.
module tb_registers_dump_unit;
  import registers_dump_unit_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int DEPTH   = 32;
  localparam int NBYTES  = DEPTH * NB_DATA / 8;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               i_start;
  logic [NB_DATA-1:0] i_reg_data;
  logic               i_tx_done;
  logic [NB_ADDR-1:0] o_reg_addr;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_done;

  always #5 i_clock = ~i_clock;

  registers_dump_unit #(
    .NB_DATA    (NB_DATA),
    .NB_ADDR    (NB_ADDR),
    .BANK_DEPTH (DEPTH)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_reg_data (i_reg_data),
    .i_tx_done  (i_tx_done),
    .o_reg_addr (o_reg_addr),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // Register bank: registered read port, read-before-write on the same edge.
  logic [NB_DATA-1:0] bank [DEPTH];
  logic               bank_clr;
  logic               wr_en;
  logic [NB_ADDR-1:0] wr_addr;
  logic [NB_DATA-1:0] wr_data;

  always @(posedge i_clock) begin
    i_reg_data <= bank[o_reg_addr];
    if (bank_clr) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  logic [NB_DATA-1:0] model [DEPTH];
  logic [7:0]         sb [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, byte_idx, done_cnt, done_cyc, last_tx_cyc;
  int tx_delay, tx_cnt;
  bit glitch_en, glitch_next;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive the TX model.
  task automatic tick();
    logic [7:0] e;
    @(negedge i_clock);
    cyc++;
    if (o_tx_start === 1'b1) begin
      check("sb_has_byte", 32'(sb.size() != 0), 32'd1);
      e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      check($sformatf("tx_byte[%0d]", byte_idx), 32'(o_tx_data), 32'(e));
      check($sformatf("tx_addr[%0d]", byte_idx), 32'(o_reg_addr), 32'(byte_idx / 4));
      if (byte_idx == 0)
        check("first_send_latency", 32'(cyc - start_cyc), 32'd3);
      else
        check($sformatf("send_gap[%0d]", byte_idx), 32'(cyc - last_tx_cyc),
              32'((byte_idx % 4 == 0) ? tx_delay + 3 : tx_delay + 1));
      last_tx_cyc = cyc;
      byte_idx++;
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    i_tx_done = 1'b0;
    if (glitch_en && glitch_next) i_tx_done = 1'b1;
    glitch_next = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        i_tx_done   = 1'b1;
        glitch_next = 1'b1;
      end
    end
    if (o_tx_start === 1'b1) begin
      tx_cnt = tx_delay;
      if (glitch_en) i_tx_done = 1'b1;
    end
  endtask

  task automatic push_dump();
    for (int r = 0; r < DEPTH; r++)
      for (int b = 0; b < 4; b++)
        sb.push_back(model[r][8*b +: 8]);
  endtask

  task automatic fill_bank();
    for (int r = 0; r < DEPTH; r++) begin
      wr_en   = 1'b1;
      wr_addr = NB_ADDR'(r);
      wr_data = model[r];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_dump(input int delay, input bit glitch);
    tx_delay  = delay;
    glitch_en = glitch;
    byte_idx  = 0;
    done_cnt  = 0;
    tx_cnt    = 0;
    i_start   = 1'b1;
    start_cyc = cyc;
    tick();
    i_start = 1'b0;
    check("busy_in_read", 32'(o_busy), 32'd1);
    check("addr_in_read", 32'(o_reg_addr), 32'd0);
    check("no_tx_start_in_read", 32'(o_tx_start), 32'd0);
  endtask

  task automatic run_dump(input int delay, input bit glitch, input int restart_at,
                          input int write_at);
    bit pulsed  = 1'b0;
    bit written = 1'b0;
    int budget  = 0;
    start_dump(delay, glitch);
    while (done_cnt == 0 && budget < 4000) begin
      i_start = 1'b0;
      wr_en   = 1'b0;
      if (restart_at >= 0 && !pulsed && byte_idx == restart_at) begin
        i_start = 1'b1;
        pulsed  = 1'b1;
      end
      if (write_at >= 0 && !written && byte_idx == write_at) begin
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hCAFEF00D;
        written = 1'b1;
      end
      tick();
      budget++;
    end
    i_start = 1'b0;
    wr_en   = 1'b0;
    check("dump_in_budget", 32'(budget < 4000), 32'd1);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("bytes_sent", 32'(byte_idx), 32'(NBYTES));
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("done_latency", 32'(done_cyc - last_tx_cyc), 32'(delay + 1));
    check("busy_in_done", 32'(o_busy), 32'd1);
    tick();
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("done_single_cycle", 32'(o_done), 32'd0);
    repeat (5) tick();
    check("no_extra_bytes", 32'(byte_idx), 32'(NBYTES));
    check("idle_after_dump", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int budget;
    i_reset = 1'b1;  i_start = 1'b0;  i_tx_done = 1'b0;
    wr_en = 1'b0;    wr_addr = '0;    wr_data = '0;   bank_clr = 1'b0;
    tx_cnt = 0;      tx_delay = 3;    glitch_en = 1'b0; glitch_next = 1'b0;
    byte_idx = 0;    done_cnt = 0;    start_cyc = 0;  last_tx_cyc = 0; done_cyc = 0;

    repeat (2) tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_addr", 32'(o_reg_addr), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    i_reset = 1'b0;
    tick();

    // All-zero bank, slow TX.
    for (int r = 0; r < DEPTH; r++) model[r] = '0;
    bank_clr = 1'b1; tick(); bank_clr = 1'b0;
    push_dump();
    run_dump(3, 1'b0, -1, -1);

    // Byte order on the first and last registers.
    model[1]  = 32'h11223344;
    model[31] = 32'hDEADBEEF;
    fill_bank();
    push_dump();
    run_dump(3, 1'b0, -1, -1);

    // Distinct pattern, back-to-back TX.
    for (int r = 0; r < DEPTH; r++)
      model[r] = {8'(r), 8'(r + 8'h40), 8'(r + 8'h80), 8'(r + 8'hC0)};
    fill_bank();
    push_dump();
    run_dump(1, 1'b0, -1, -1);

    // Stray i_start mid-dump and i_tx_done outside WAIT_TX.
    push_dump();
    run_dump(3, 1'b1, 60, -1);

    // Write reg5 while reg3 is being sent.
    model[5] = 32'hCAFEF00D;
    push_dump();
    run_dump(2, 1'b0, -1, 13);

    // Reset during byte 50's WAIT_TX, then a full fresh dump.
    push_dump();
    start_dump(3, 1'b0);
    budget = 0;
    while (byte_idx < 51 && budget < 2000) begin
      tick();
      budget++;
    end
    check("reach_byte50", 32'(budget < 2000), 32'd1);
    tick();
    check("tx_data_byte50", 32'(o_tx_data), 32'(model[12][23:16]));
    #1 i_reset = 1'b1;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_tx_start", 32'(o_tx_start), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_addr", 32'(o_reg_addr), 32'd0);
    check("midrst_tx_data", 32'(o_tx_data), 32'd0);
    tick();
    tick();
    i_reset = 1'b0;
    tx_cnt  = 0;
    sb.delete();
    tick();
    push_dump();
    run_dump(3, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
